// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair.
package pwm_pkg;

  // Default counter width, shared with the generator so loopback widths agree.
  localparam int PWM_MAX_WAVE = 24;

  // Capture FSM states.
  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,  // waiting for the first rising edge
    CAP_HIGH = 2'd1,  // input is high, timing the high phase
    CAP_LOW  = 2'd2   // input is low, waiting for the closing rising edge
  } cap_state_e;

endpackage : pwm_pkg

// File: rtl/pwm_sync_edge.sv
// Synchronizes an asynchronous level and reports its rising/falling edges.
// SYNC_STAGES must be at least 2.
module pwm_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Shift the input through the synchronizer chain; prev holds the synced level one cycle older.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state is written with <= only, so every flop samples the pre-edge values.
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      prev   <= synced;
    end
  end

  // Both edges come from the same delayed pair, so they see identical latency.
  assign rise = synced & ~prev;
  assign fall = ~synced & prev;

endmodule : pwm_sync_edge

// File: rtl/pwm_capture.sv
// Measures an incoming PWM waveform: period and high time in clk cycles,
// one measurement per complete period, with a sticky timeout on a stalled input.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int MAX_WAVE    = PWM_MAX_WAVE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pwm_in,
  output logic [MAX_WAVE-1:0] period,
  output logic [MAX_WAVE-1:0] high_time,
  output logic                valid,
  output logic                timeout
);

  localparam logic [MAX_WAVE-1:0] CNT_MAX = '1;
  localparam logic [MAX_WAVE-1:0] CNT_ONE = MAX_WAVE'(1);

  logic                rise;
  logic                fall;
  logic [MAX_WAVE-1:0] counter;
  logic [MAX_WAVE-1:0] hi_latch;
  logic                sat;
  cap_state_e          state;

  pwm_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk   (clk),
    .rst   (rst),
    .pwm_in(pwm_in),
    .rise  (rise),
    .fall  (fall)
  );

  assign sat = (counter == CNT_MAX);

  // Cycles since the last rise: restart at 1 on a rise, otherwise count up and stick at the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter <= '0;
    end else if (rise) begin
      counter <= CNT_ONE;
    end else if (!sat) begin
      counter <= counter + CNT_ONE;
    end
  end

  // Capture FSM with registered outputs; an edge always wins over saturation in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CAP_IDLE;
      hi_latch  <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      // NOTE: valid defaults low every cycle so it can only ever be a one-cycle strobe.
      valid <= 1'b0;
      case (state)
        CAP_IDLE: begin
          if (rise) state <= CAP_HIGH;
        end
        CAP_HIGH: begin
          if (fall) begin
            hi_latch <= counter;
            state    <= CAP_LOW;
          end else if (sat) begin
            timeout <= 1'b1;
            state   <= CAP_IDLE;
          end
        end
        CAP_LOW: begin
          if (rise) begin
            period    <= counter;
            high_time <= hi_latch;
            valid     <= 1'b1;
            timeout   <= 1'b0;
            state     <= CAP_HIGH;
          end else if (sat) begin
            timeout <= 1'b1;
            state   <= CAP_IDLE;
          end
        end
        default: state <= CAP_IDLE;
      endcase
    end
  end

endmodule : pwm_capture

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: two instances (default width and a 4-bit one for
// timeouts) share one randomized input; a timestamp model predicts the outputs.
module tb_pwm_capture;
  import pwm_pkg::*;

  localparam int S  = 2;
  localparam int W0 = PWM_MAX_WAVE;
  localparam int W1 = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pwm_in = 1'b0;
  logic [W0-1:0] period0, high0;
  logic [W1-1:0] period1, high1;
  logic          valid0, timeout0, valid1, timeout1;

  pwm_capture #(.MAX_WAVE(W0), .SYNC_STAGES(S)) dut0 (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .period(period0), .high_time(high0), .valid(valid0), .timeout(timeout0)
  );

  pwm_capture #(.MAX_WAVE(W1), .SYNC_STAGES(S)) dut1 (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .period(period1), .high_time(high1), .valid(valid1), .timeout(timeout1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on sample timestamps: raw[n] is pwm_in as seen at clock edge n.
  // A level change sampled at edge r is acted on at edge r+S. A period closes
  // at a rise when an earlier rise and a fall since it are known; period is the
  // distance between rises, high time the distance from rise to fall.
  bit     raw [int];
  int     n        = 0;
  int     last_rst = -1;
  longint maxv  [2];
  bit     armed [2];
  bit     fell  [2];
  int     lr    [2];
  int     ft    [2];
  longint e_p   [2];
  longint e_h   [2];
  bit     e_v   [2];
  bit     e_t   [2];

  function automatic bit samp(input int m);
    if (m < 0 || m <= last_rst) return 1'b0;
    return raw[m];
  endfunction

  initial begin
    maxv[0] = (longint'(1) << W0) - 1;
    maxv[1] = (longint'(1) << W1) - 1;
    for (int k = 0; k < 2; k++) begin
      armed[k] = 0; fell[k] = 0; lr[k] = 0; ft[k] = 0;
      e_p[k] = 0; e_h[k] = 0; e_v[k] = 0; e_t[k] = 0;
    end
  end

  always @(posedge clk) begin
    bit     rise_ev, fall_ev;
    longint p;
    n++;
    if (rst) begin
      last_rst = n;
      for (int k = 0; k < 2; k++) begin
        armed[k] = 0; fell[k] = 0;
        e_p[k] = 0; e_h[k] = 0; e_v[k] = 0; e_t[k] = 0;
      end
    end else begin
      raw[n]  = pwm_in;
      rise_ev = samp(n - S) && !samp(n - S - 1);
      fall_ev = !samp(n - S) && samp(n - S - 1);
      for (int k = 0; k < 2; k++) begin
        p = longint'(n - lr[k]);
        if (p > maxv[k]) p = maxv[k];
        e_v[k] = 0;
        if (rise_ev) begin
          if (armed[k] && fell[k]) begin
            e_v[k] = 1;
            e_p[k] = p;
            e_h[k] = longint'(ft[k] - lr[k]);
            e_t[k] = 0;
          end
          armed[k] = 1; fell[k] = 0; lr[k] = n;
        end else if (fall_ev && armed[k] && !fell[k]) begin
          fell[k] = 1; ft[k] = n;
        end else if (armed[k] && longint'(n - lr[k]) >= maxv[k]) begin
          e_t[k] = 1;
          armed[k] = 0;
        end
      end
    end
  end

  // Compare every cycle, 1 time unit after the active edge.
  bit chk_en = 1'b1;
  bit last_v0 = 1'b0;
  always @(posedge clk) begin
    if (chk_en) begin
      #1;
      check("valid0",   valid0,   e_v[0]);
      check("period0",  period0,  e_p[0]);
      check("high0",    high0,    e_h[0]);
      check("timeout0", timeout0, e_t[0]);
      check("valid1",   valid1,   e_v[1]);
      check("period1",  period1,  e_p[1]);
      check("high1",    high1,    e_h[1]);
      check("timeout1", timeout1, e_t[1]);
      if (last_v0) check("valid0_back2back", valid0, 0);
      last_v0 = valid0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    repeat (reps) begin
      pwm_in = 1'b1; cycles(hi);
      pwm_in = 1'b0; cycles(lo);
    end
  endtask

  int first_valid_edge;

  initial begin
    // Reset held 3 cycles with the input toggling.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pwm_in = ~pwm_in;
    end
    pwm_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cycles(2);

    // Steady 3/5, plus a directed latency check on the first valid.
    pwm_in = 1'b1;
    @(posedge clk);
    first_valid_edge = -1;
    fork
      begin
        for (int e = 1; e <= 40 && first_valid_edge < 0; e++) begin
          #1;
          if (valid0) first_valid_edge = e;
          @(posedge clk);
        end
      end
      begin
        @(negedge clk);
        cycles(2);
        pwm_in = 1'b0; cycles(5);
        wave(3, 5, 5);
      end
    join
    // First sampled high is edge 1, second rise sampled at edge 9, valid after S more edges.
    check("latency_3_5", first_valid_edge, 9 + S);
    check("dir_period_3_5", period0, 8);
    check("dir_high_3_5",   high0,   3);

    // Minimum waveform 1/1.
    wave(1, 1, 10);
    check("dir_period_1_1", period0, 2);
    check("dir_high_1_1",   high0,   1);

    // Duty change 3/5 -> 6/2.
    wave(3, 5, 4);
    wave(6, 2, 4);
    pwm_in = 1'b1; cycles(4);
    check("dir_period_6_2", period0, 8);
    check("dir_high_6_2",   high0,   6);

    // Timeout on the 4-bit instance: one pulse, then hold low.
    pwm_in = 1'b0; cycles(30);
    check("dir_timeout1_set",  timeout1, 1);
    check("dir_timeout0_clr",  timeout0, 0);
    check("dir_period1_held",  period1,  8);
    wave(2, 4, 3);
    check("dir_timeout1_clr",  timeout1, 0);
    check("dir_period1_2_4",   period1,  6);
    check("dir_high1_2_4",     high1,    2);

    // Reset while in LOW after a 4-cycle high.
    wave(3, 5, 3);
    pwm_in = 1'b1; cycles(4);
    pwm_in = 1'b0; cycles(4);
    rst = 1'b1; cycles(1);
    rst = 1'b0;
    check("dir_rst_period0", period0, 0);
    cycles(6);
    wave(3, 5, 4);

    // Constant high long enough to time out the 4-bit instance in HIGH.
    pwm_in = 1'b1; cycles(25);
    pwm_in = 1'b0; cycles(3);

    // Randomized waveforms with occasional long gaps and resets.
    for (int i = 0; i < 400; i++) begin
      int hi, lo;
      hi = int'($urandom_range(1, 8));
      lo = ($urandom_range(0, 15) == 0) ? int'($urandom_range(14, 22))
                                        : int'($urandom_range(1, 8));
      if ($urandom_range(0, 10) == 0) hi = int'($urandom_range(12, 20));
      wave(hi, lo, 1);
      if ($urandom_range(0, 60) == 0) begin
        rst = 1'b1; cycles(int'($urandom_range(1, 3)));
        rst = 1'b0;
      end
    end
    pwm_in = 1'b0; cycles(5);

    chk_en = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pwm_capture

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the team's PWM generator: measures an incoming PWM waveform and reports period and high time in clock cycles.
- Used for loopback checking of generated tones and for reading external PWM sources.
- Synchronizes the asynchronous input, detects edges, counts cycles and emits one measurement per complete period with a single-cycle valid strobe.

Parameters:
- MAX_WAVE, 24, width of the cycle counter and of the period/high_time outputs.
- SYNC_STAGES, 2, number of synchronizer flops on pwm_in (minimum 2).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- pwm_in  input  1  asynchronous PWM waveform to measure.
- period  output  MAX_WAVE  cycles between the last two rising edges; holds until the next valid.
- high_time  output  MAX_WAVE  cycles from rising to falling edge within that period; holds until the next valid.
- valid  output  1  one-cycle strobe: period/high_time updated this cycle.
- timeout  output  1  sticky flag: counter saturated with no edge; cleared by the next valid or by rst.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is synchronous and active-high.
  - Reset values: period=0, high_time=0, valid=0, timeout=0, counter=0, synchronizer flops=0, edge-history flop=0, state=IDLE.
- Input path: pwm_in passes through SYNC_STAGES flops.
  - rise = synced & ~prev.
  - fall = ~synced & prev.
  - prev is the synced value delayed one cycle.
  - Both edges see identical delay, so measurements are exact in clk cycles.
- Counter:
  - Set to 1 on the cycle a rise is detected.
  - Otherwise increments by 1 each cycle, saturating at 2^MAX_WAVE-1.
  - The counter value on an edge cycle equals the cycles elapsed since the last rise.
- States:
  - IDLE: ignore fall. On rise: counter<=1, go HIGH. No output update.
  - HIGH: on fall: hi_latch<=counter, go LOW. On saturation: timeout<=1, go IDLE.
  - LOW: on rise, all in the same cycle:
    - period<=counter
    - high_time<=hi_latch
    - valid<=1
    - timeout<=0
    - counter<=1
    - go HIGH.
  - LOW: on saturation: timeout<=1, go IDLE.
- Latency: valid is registered, asserting the cycle after the rise is detected. From the first clk edge that samples pwm_in high, valid is high after SYNC_STAGES+1 edges.
- First measurement after reset or timeout is produced at the second detected rise. Partial periods are never reported.
- Minimum measurable waveform: 1 cycle high, 1 cycle low gives period=2, high_time=1, and valid every 2 cycles.
- Constant input (0% or 100% duty) yields no valid. timeout asserts when the counter reaches 2^MAX_WAVE-1. period/high_time keep their last values.
- Glitches shorter than one clk period may be missed. This is not an error condition.
- rst mid-measurement discards all progress. No valid is issued for the interrupted period.
- Arithmetic: unsigned MAX_WAVE-bit counts, no wrap (saturation only).
- valid is never high two consecutive cycles.

Decomposition:
- Shared package pwm_pkg:
  - capture state encoding (IDLE, HIGH, LOW)
  - default MAX_WAVE constant, shared with the generator.
- Sub-module pwm_sync_edge: SYNC_STAGES synchronizer, prev flop, rise/fall outputs.
- The top holds the FSM, counter, latches and outputs (about 150 lines total).

Test Plan:
- Reset check: hold rst 3 cycles with pwm_in toggling -> period=0, high_time=0, valid=0, timeout=0 throughout and on the first cycle after release.
- Steady 3 high / 5 low waveform -> first valid SYNC_STAGES+1 edges after the second sampled rise. Then valid every 8 cycles with period=8, high_time=3.
- Minimum pulse, 1 high / 1 low -> period=2, high_time=1, valid every 2 cycles.
- Timeout, MAX_WAVE=4: one rise and fall, then hold low.
  - timeout=1 when the counter reaches 15; no valid; outputs held.
  - Resume a 2/4 waveform -> timeout stays 1 until the first valid (period=6, high_time=2), then 0.
- Duty change mid-stream 3/5 -> 6/2 -> the valid following the change reports period=8, high_time=6. No spurious intermediate valid.
- rst asserted for one cycle while in LOW after a 4-cycle high -> no valid from that period. The next valid appears only after two fresh rises.
